conv_last_to_first_with_ready: RTL and testbench

Converts a stream tagged with a `last` status signal into one that also carries a `first` status signal, plus a per-beat index within the packet. It is the counterpart of the first-to-last converter: it sits where a producer marks packet ends and a consumer needs packet starts. Full valid/ready handshake on both sides. A 2-entry skid buffer gives registered outputs and full throughput.

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_last_to_first_with_ready_skid_buffer_2.sv | 93 +++++++++
 rtl/conv_last_to_first_with_ready.sv | 103 ++++++++++
 tb/tb_conv_last_to_first_with_ready.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// ----------------------------------------------------------------------------
// conv_pkg
// Shared helpers for the stream-tagging converters.
//
// Contents:
//   sat_inc(value, max_value) - increment that sticks at max_value. Used for
//                               the per-packet beat index so that very long
//                               packets report the top index on every beat
//                               past the limit.
// ----------------------------------------------------------------------------
package conv_pkg;

    // 32 bits covers any practical index width; callers cast in and out.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/conv_last_to_first_with_ready_skid_buffer_2.sv
// ----------------------------------------------------------------------------
// skid_buffer_2
// Two-entry valid/ready pipeline stage: a main (output) register plus one
// overflow (skid) register. All outputs come straight from flops, and the
// stage sustains one beat per cycle while the consumer is ready.
//
// Ports:
//   clock         in   clock, all state on the rising edge
//   reset_n       in   asynchronous active-low reset
//   up_valid      in   upstream beat valid
//   up_ready      out  stage can accept a beat (registered, = skid empty)
//   up_payload    in   upstream payload
//   down_valid    out  main register holds a beat
//   down_ready    in   downstream accepts the beat
//   down_payload  out  main register contents
// ----------------------------------------------------------------------------
module skid_buffer_2
    import conv_pkg::*;
#(
    parameter int unsigned payload_width = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     up_valid,
    output logic                     up_ready,
    input  logic [payload_width-1:0] up_payload,
    output logic                     down_valid,
    input  logic                     down_ready,
    output logic [payload_width-1:0] down_payload
);

    logic                     main_valid_reg, main_valid_next;
    logic [payload_width-1:0] main_data_reg,  main_data_next;
    logic                     skid_valid_reg, skid_valid_next;
    logic [payload_width-1:0] skid_data_reg,  skid_data_next;
    logic                     up_ready_reg;

    logic accept;
    logic drain;

    assign accept = up_valid && up_ready_reg;
    assign drain  = main_valid_reg && down_ready;

    always_comb begin
        main_valid_next = main_valid_reg;
        main_data_next  = main_data_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;

        if (!main_valid_reg || drain) begin
            // Main is free this cycle. The skid beat is older than anything
            // arriving now, so it always wins. up_ready is low whenever the
            // skid is occupied, so the two sources never compete.
            if (skid_valid_reg) begin
                main_valid_next = 1'b1;
                main_data_next  = skid_data_reg;
                skid_valid_next = 1'b0;
            end else if (accept) begin
                main_valid_next = 1'b1;
                main_data_next  = up_payload;
            end else begin
                main_valid_next = 1'b0;
            end
        end else if (accept) begin
            // Main is full and stalled: park the beat in the skid.
            skid_valid_next = 1'b1;
            skid_data_next  = up_payload;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            main_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            up_ready_reg   <= 1'b0;
        end else begin
            main_valid_reg <= main_valid_next;
            main_data_reg  <= main_data_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
            // Ready is a flop copy of "skid will be empty", so it is held low
            // during reset and rises on the first edge after release.
            up_ready_reg   <= !skid_valid_next;
        end
    end

    assign up_ready     = up_ready_reg;
    assign down_valid   = main_valid_reg;
    assign down_payload = main_data_reg;

endmodule

// File: rtl/conv_last_to_first_with_ready.sv
// ----------------------------------------------------------------------------
// conv_last_to_first_with_ready
// Takes a stream that marks packet ends (up_last) and adds a packet-start
// flag (down_first) plus a saturating 0-based beat index. Tagging happens at
// upstream accept time; a 2-entry skid buffer gives registered outputs and
// full throughput.
//
// Ports:
//   clock       in   clock, all state on the rising edge
//   reset_n     in   asynchronous active-low reset
//   up_valid    in   upstream beat valid
//   up_ready    out  block can accept a beat
//   up_last     in   beat is the last of its packet
//   up_data     in   beat payload [width]
//   down_valid  out  output beat valid
//   down_ready  in   downstream accepts the beat
//   down_first  out  beat is the first of its packet
//   down_last   out  up_last carried through with its beat
//   down_data   out  beat payload [width]
//   down_index  out  beat position in packet, saturating [idx_width]
// ----------------------------------------------------------------------------
module conv_last_to_first_with_ready
    import conv_pkg::*;
#(
    parameter int unsigned width     = 8,
    parameter int unsigned idx_width = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 up_valid,
    output logic                 up_ready,
    input  logic                 up_last,
    input  logic [width-1:0]     up_data,
    output logic                 down_valid,
    input  logic                 down_ready,
    output logic                 down_first,
    output logic                 down_last,
    output logic [width-1:0]     down_data,
    output logic [idx_width-1:0] down_index
);

    typedef struct packed {
        logic [width-1:0]     data;
        logic                 first;
        logic                 last;
        logic [idx_width-1:0] index;
    } beat_t;

    localparam int unsigned BEAT_W  = $bits(beat_t);
    localparam logic [31:0] IDX_MAX = 32'((64'd1 << idx_width) - 64'd1);

    logic                 expect_first_reg;
    logic [idx_width-1:0] index_reg;

    beat_t beat_in;
    beat_t beat_out;
    logic  accept;

    assign accept = up_valid && up_ready;

    always_comb begin
        beat_in.data  = up_data;
        beat_in.first = expect_first_reg;
        beat_in.last  = up_last;
        // index_reg holds the index of the previously accepted beat.
        if (expect_first_reg) begin
            beat_in.index = '0;
        end else begin
            beat_in.index = idx_width'(sat_inc(32'(index_reg), IDX_MAX));
        end
    end

    // Only accepted beats advance the packet state, so upstream gaps and
    // unacknowledged valid pulses leave flag and index untouched.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            expect_first_reg <= 1'b1;
            index_reg        <= '0;
        end else if (accept) begin
            expect_first_reg <= up_last;
            index_reg        <= beat_in.index;
        end
    end

    skid_buffer_2 #(
        .payload_width (BEAT_W)
    ) u_skid (
        .clock        (clock),
        .reset_n      (reset_n),
        .up_valid     (up_valid),
        .up_ready     (up_ready),
        .up_payload   (beat_in),
        .down_valid   (down_valid),
        .down_ready   (down_ready),
        .down_payload (beat_out)
    );

    assign down_first = beat_out.first;
    assign down_last  = beat_out.last;
    assign down_data  = beat_out.data;
    assign down_index = beat_out.index;

endmodule

// File: tb/tb_conv_last_to_first_with_ready.sv
// ----------------------------------------------------------------------------
// tb_conv_last_to_first_with_ready
// Directed bench for the last-to-first converter. Two instances share the
// stimulus: one with the default 8-bit index, one with a 2-bit index to show
// saturation. Inputs change 1 time unit after the rising edge; outputs are
// checked at that point (directed steps) or on the falling edge (random run).
// ----------------------------------------------------------------------------
module tb_conv_last_to_first_with_ready;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       up_valid = 1'b0;
    logic       up_last = 1'b0;
    logic [7:0] up_data = 8'h00;
    logic       down_ready = 1'b0;

    logic       up_ready, down_valid, down_first, down_last;
    logic [7:0] down_data, down_index;

    logic       up_ready2, down_valid2, down_first2, down_last2;
    logic [7:0] down_data2;
    logic [1:0] down_index2;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    conv_last_to_first_with_ready #(.width(8), .idx_width(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_last    (up_last),
        .up_data    (up_data),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_first (down_first),
        .down_last  (down_last),
        .down_data  (down_data),
        .down_index (down_index)
    );

    conv_last_to_first_with_ready #(.width(8), .idx_width(2)) dut2 (
        .clock      (clock),
        .reset_n    (reset_n),
        .up_valid   (up_valid),
        .up_ready   (up_ready2),
        .up_last    (up_last),
        .up_data    (up_data),
        .down_valid (down_valid2),
        .down_ready (down_ready),
        .down_first (down_first2),
        .down_last  (down_last2),
        .down_data  (down_data2),
        .down_index (down_index2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %0d %s observed=%0h expected=%0h", checks, tag, obs, exp);
    endtask

    // One packed compare of the whole output beat of the 8-bit-index instance.
    task automatic chk_beat(input string tag, input logic f, input logic l,
                            input logic [7:0] d, input logic [7:0] idx);
        chk(tag, {down_valid, down_first, down_last, down_data, down_index},
                 {1'b1, f, l, d, idx});
    endtask

    task automatic drive(input logic v, input logic l, input logic [7:0] d, input logic r);
        up_valid   = v;
        up_last    = l;
        up_data    = d;
        down_ready = r;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int t1_last  [6] = '{0, 0, 1, 1, 0, 1};
    int t1_first [6] = '{1, 0, 0, 1, 1, 0};
    int t1_idx   [6] = '{0, 1, 2, 0, 0, 1};
    int t4_idx2  [6] = '{0, 1, 2, 3, 3, 3};

    initial begin
        logic [17:0] q[$];
        logic [17:0] cur, exp_b, hold_val;
        logic        m_exp_first, prev_last, hold_valid;
        logic [7:0]  m_idx, nidx;
        int          acc, cyc;

        // ---------------- reset state ----------------
        #2;
        chk("rst_outputs", {down_valid, down_first, down_last, down_data, down_index}, 19'd0);
        chk("rst_up_ready", up_ready, 1'b0);
        chk("rst_up_ready_idx2", up_ready2, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        chk("release_up_ready", up_ready, 1'b1);
        chk("release_down_valid", down_valid, 1'b0);

        // ---------------- packets 3,1,2 back to back ----------------
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, t1_last[i][0], 8'(8'h10 + i), 1'b1);
            tick();
            chk_beat("pkts_312_beat", t1_first[i][0], t1_last[i][0], 8'(8'h10 + i), 8'(t1_idx[i]));
            chk("pkts_312_up_ready", up_ready, 1'b1);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        chk("pkts_312_idle", down_valid, 1'b0);

        // ---------------- backpressure, 3 stalled cycles ----------------
        drive(1'b1, 1'b0, 8'hA0, 1'b1);
        tick();
        chk_beat("bp_a0", 1'b1, 1'b0, 8'hA0, 8'd0);
        chk("bp_ready_a0", up_ready, 1'b1);
        drive(1'b1, 1'b0, 8'hA1, 1'b0);
        tick();
        chk_beat("bp_stall1", 1'b1, 1'b0, 8'hA0, 8'd0);
        chk("bp_ready_stall1", up_ready, 1'b0);
        drive(1'b1, 1'b0, 8'hA2, 1'b0);
        tick();
        chk_beat("bp_stall2", 1'b1, 1'b0, 8'hA0, 8'd0);
        chk("bp_ready_stall2", up_ready, 1'b0);
        tick();
        chk_beat("bp_stall3", 1'b1, 1'b0, 8'hA0, 8'd0);
        chk("bp_ready_stall3", up_ready, 1'b0);
        drive(1'b1, 1'b0, 8'hA2, 1'b1);
        tick();
        chk_beat("bp_a1", 1'b0, 1'b0, 8'hA1, 8'd1);
        chk("bp_ready_recover", up_ready, 1'b1);
        tick();
        chk_beat("bp_a2", 1'b0, 1'b0, 8'hA2, 8'd2);
        drive(1'b1, 1'b1, 8'hA3, 1'b1);
        tick();
        chk_beat("bp_a3", 1'b0, 1'b1, 8'hA3, 8'd3);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        chk("bp_idle", down_valid, 1'b0);

        // ---------------- gaps inside a packet ----------------
        drive(1'b1, 1'b0, 8'hB0, 1'b1);
        tick();
        chk_beat("gap_b0", 1'b1, 1'b0, 8'hB0, 8'd0);
        drive(1'b0, 1'b0, 8'hEE, 1'b1);
        tick();
        chk("gap_idle1", down_valid, 1'b0);
        drive(1'b1, 1'b0, 8'hB1, 1'b1);
        tick();
        chk_beat("gap_b1", 1'b0, 1'b0, 8'hB1, 8'd1);
        drive(1'b0, 1'b1, 8'hEE, 1'b1);
        tick();
        tick();
        chk("gap_idle2", down_valid, 1'b0);
        drive(1'b1, 1'b1, 8'hB2, 1'b1);
        tick();
        chk_beat("gap_b2", 1'b0, 1'b1, 8'hB2, 8'd2);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        tick();

        // ---------------- 6-beat packet, index saturation ----------------
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, (i == 5), 8'(8'hC0 + i), 1'b1);
            tick();
            chk_beat("long_idx8", (i == 0), (i == 5), 8'(8'hC0 + i), 8'(i));
            chk("long_idx2", {down_valid2, down_first2, down_last2, down_data2, down_index2},
                             {1'b1, (i == 0), (i == 5), 8'(8'hC0 + i), 2'(t4_idx2[i])});
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        tick();

        // ---------------- reset mid-packet ----------------
        drive(1'b1, 1'b0, 8'hD0, 1'b0);
        tick();
        chk_beat("rstmid_d0", 1'b1, 1'b0, 8'hD0, 8'd0);
        drive(1'b1, 1'b0, 8'hD1, 1'b0);
        tick();
        chk("rstmid_full", up_ready, 1'b0);
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        chk("rstmid_outputs", {down_valid, down_first, down_last, down_data, down_index}, 19'd0);
        chk("rstmid_up_ready", up_ready, 1'b0);
        #2;
        reset_n = 1'b1;
        tick();
        chk("rstmid_release_ready", up_ready, 1'b1);
        drive(1'b1, 1'b1, 8'hD5, 1'b1);
        tick();
        chk_beat("rstmid_next_first", 1'b1, 1'b1, 8'hD5, 8'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        tick();

        // ---------------- random valid/ready with scoreboard ----------------
        m_exp_first = 1'b1;
        m_idx       = 8'd0;
        prev_last   = 1'b1;
        hold_valid  = 1'b0;
        hold_val    = '0;
        acc         = 0;
        cyc         = 0;
        while ((acc < 10000 || q.size() != 0) && cyc < 60000) begin
            up_valid   = (acc < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            up_data    = 8'($urandom);
            up_last    = ($urandom_range(0, 3) == 0);
            down_ready = 1'($urandom_range(0, 1));
            @(negedge clock);
            cur = {down_first, down_last, down_data, down_index};
            if (hold_valid)
                chk("rand_stable", {down_valid, cur}, {1'b1, hold_val});
            // Pop before push so a beat accepted this cycle is never matched
            // against the output of the same cycle.
            if (down_valid && down_ready) begin
                if (q.size() != 0) exp_b = q.pop_front();
                else               exp_b = 'x;
                chk("rand_beat", cur, exp_b);
                chk("rand_first_follows_last", down_first, prev_last);
                prev_last = down_last;
            end
            if (up_valid && up_ready) begin
                if (m_exp_first)        nidx = 8'd0;
                else if (m_idx == 8'hFF) nidx = 8'hFF;
                else                    nidx = m_idx + 8'd1;
                q.push_back({m_exp_first, up_last, up_data, nidx});
                m_idx       = nidx;
                m_exp_first = up_last;
                acc++;
            end
            hold_valid = down_valid && !down_ready;
            hold_val   = cur;
            @(posedge clock);
            #1;
            cyc++;
        end
        chk("rand_drained", q.size(), 0);
        chk("rand_all_accepted", acc, 10000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
